// File: rtl/utopia1_atm_rx_if.sv
// UTOPIA Level 1 receive bundle: PHY byte port (clav/soc/data/en) plus the core-side cell handshake.
// master = receiver view, slave = PHY/core environment view.
interface utopia1_atm_rx_if #(
    parameter int unsigned CNT_W = 16
);
    logic             clav;
    logic             soc;
    logic [7:0]       data;
    logic             en;
    logic             valid;
    logic             ready;
    logic [11:0]      vpi;
    logic [15:0]      vci;
    logic             clp;
    logic [2:0]       pt;
    logic [7:0]       hec;
    logic [383:0]     payload;
    logic [CNT_W-1:0] cell_count;
    logic             abort;
    logic             hec_err;

    modport master (
        input  clav, soc, data, ready,
        output en, valid, vpi, vci, clp, pt, hec, payload, cell_count, abort, hec_err
    );
    modport slave (
        output clav, soc, data, ready,
        input  en, valid, vpi, vci, clp, pt, hec, payload, cell_count, abort, hec_err
    );
endinterface

// File: rtl/utopia1_atm_rx.sv
// UTOPIA Level 1 ATM-layer receiver: byte-serial NNI cell capture with stall timeout and valid/ready delivery.
// Define UTOPIA_RX_HEC_CHECK_EN to build the header CRC-8 checker that drops cells with a bad HEC.
module utopia1_atm_rx #(
    parameter int unsigned STALL_LIMIT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_in,
    input  logic             reset,
    output logic             clk_out,
    utopia1_atm_rx_if.master bus
);
    localparam int unsigned IDX_W   = 6;
    localparam int unsigned STALL_W = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(52);
    localparam logic [IDX_W-1:0] PAY_IDX  = IDX_W'(5);

    typedef enum logic [1:0] {HUNT, RECV, DELIVER} state_t;

    state_t             state, nextState;
    logic [IDX_W-1:0]   byteIdx, nextIdx, capIdx;
    logic [STALL_W-1:0] stallCnt, nextStall;
    logic               capture, countInc, xfer;
    logic               nextEn, nextValid, nextAbort;
    logic               enReg, validReg, abortReg;
    logic [11:0]        vpiReg;
    logic [15:0]        vciReg;
    logic               clpReg;
    logic [2:0]         ptReg;
    logic [7:0]         hecReg;
    logic [383:0]       payReg;
    logic [CNT_W-1:0]   countReg;
    logic [5:0]         payByte;
    logic [8:0]         payBase;

`ifdef UTOPIA_RX_HEC_CHECK_EN
    localparam logic [IDX_W-1:0] HEC_IDX = IDX_W'(4);
    logic [7:0] crcReg;
    logic       nextHecErr, hecErrReg;
`endif

    assign clk_out = clk_in;
    assign xfer    = ~enReg;
    assign payByte = capIdx - PAY_IDX;
    assign payBase = {payByte, 3'b000};

    // State register
    always_ff @(posedge clk_in) begin
        if (reset) state <= HUNT;
        else       state <= nextState;
    end

    // Next-state and per-cycle control
    always_comb begin
        nextState = state;
        nextIdx   = byteIdx;
        nextStall = stallCnt;
        nextEn    = ~bus.clav;
        nextValid = validReg;
        nextAbort = 1'b0;
        capture   = 1'b0;
        capIdx    = byteIdx;
        countInc  = 1'b0;
`ifdef UTOPIA_RX_HEC_CHECK_EN
        nextHecErr = 1'b0;
`endif
        unique case (state)
            HUNT: begin
                nextIdx   = '0;
                nextStall = '0;
                if (xfer && bus.soc) begin
                    capture   = 1'b1;
                    capIdx    = '0;
                    nextIdx   = IDX_W'(1);
                    nextState = RECV;
                end
            end
            RECV: begin
                if (xfer) begin
                    nextStall = '0;
                    capture   = 1'b1;
                    if (bus.soc) begin
                        // Resync: the soc byte starts a fresh cell
                        nextAbort = 1'b1;
                        capIdx    = '0;
                        nextIdx   = IDX_W'(1);
                    end else if (byteIdx == LAST_IDX) begin
                        nextIdx   = '0;
                        nextEn    = 1'b1;
                        nextValid = 1'b1;
                        nextState = DELIVER;
                    end else begin
                        nextIdx = byteIdx + IDX_W'(1);
`ifdef UTOPIA_RX_HEC_CHECK_EN
                        if (byteIdx == HEC_IDX && bus.data != (crcReg ^ 8'h55)) begin
                            nextHecErr = 1'b1;
                            nextIdx    = '0;
                            nextState  = HUNT;
                        end
`endif
                    end
                end else if (STALL_LIMIT != 0) begin
                    if (stallCnt == STALL_W'(STALL_LIMIT - 1)) begin
                        nextAbort = 1'b1;
                        nextStall = '0;
                        nextIdx   = '0;
                        nextState = HUNT;
                    end else begin
                        nextStall = stallCnt + STALL_W'(1);
                    end
                end
            end
            DELIVER: begin
                nextEn    = 1'b1;
                nextStall = '0;
                if (validReg && bus.ready) begin
                    nextValid = 1'b0;
                    countInc  = 1'b1;
                    nextState = HUNT;
                end
            end
            default: nextState = HUNT;
        endcase
    end

    // Datapath: byte capture into header fields / payload, flow control and status
    always_ff @(posedge clk_in) begin
        if (reset) begin
            byteIdx  <= '0;
            stallCnt <= '0;
            enReg    <= 1'b1;
            validReg <= 1'b0;
            abortReg <= 1'b0;
            countReg <= '0;
            vpiReg   <= '0;
            vciReg   <= '0;
            clpReg   <= 1'b0;
            ptReg    <= '0;
            hecReg   <= '0;
            payReg   <= '0;
        end else begin
            byteIdx  <= nextIdx;
            stallCnt <= nextStall;
            enReg    <= nextEn;
            validReg <= nextValid;
            abortReg <= nextAbort;
            if (countInc) countReg <= countReg + CNT_W'(1);
            if (capture) begin
                case (capIdx)
                    IDX_W'(0): vpiReg[11:4] <= bus.data;
                    IDX_W'(1): begin
                        vpiReg[3:0]   <= bus.data[7:4];
                        vciReg[15:12] <= bus.data[3:0];
                    end
                    IDX_W'(2): vciReg[11:4] <= bus.data;
                    IDX_W'(3): begin
                        vciReg[3:0] <= bus.data[7:4];
                        clpReg      <= bus.data[3];
                        ptReg       <= bus.data[2:0];
                    end
                    IDX_W'(4): hecReg <= bus.data;
                    default:   payReg[payBase +: 8] <= bus.data;
                endcase
            end
        end
    end

`ifdef UTOPIA_RX_HEC_CHECK_EN
    function automatic logic [7:0] crc8Step(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        c = crc;
        for (int b = 7; b >= 0; b--) begin
            c = {c[6:0], 1'b0} ^ ((c[7] ^ d[b]) ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    // Running CRC over header bytes 0..3; a new cell restarts it from zero
    always_ff @(posedge clk_in) begin
        if (reset) begin
            crcReg    <= '0;
            hecErrReg <= 1'b0;
        end else begin
            hecErrReg <= nextHecErr;
            if (capture && capIdx < HEC_IDX)
                crcReg <= crc8Step((capIdx == '0) ? 8'h00 : crcReg, bus.data);
        end
    end

    assign bus.hec_err = hecErrReg;
`else
    assign bus.hec_err = 1'b0;
`endif

    assign bus.en         = enReg;
    assign bus.valid      = validReg;
    assign bus.abort      = abortReg;
    assign bus.cell_count = countReg;
    assign bus.vpi        = vpiReg;
    assign bus.vci        = vciReg;
    assign bus.clp        = clpReg;
    assign bus.pt         = ptReg;
    assign bus.hec        = hecReg;
    assign bus.payload    = payReg;
endmodule

// File: tb/tb_utopia1_atm_rx.sv
// Self-checking bench for utopia1_atm_rx: a queue-driven PHY, a core with random ready latency,
// and a reference model that derives expected fields from the 53-byte cell image.
`timescale 1ns/1ps
module tb_utopia1_atm_rx;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned STALL_LIMIT = 8;

    typedef struct packed { logic soc; logic [7:0] d; } phyByte_t;
    typedef struct packed {
        logic [11:0]  vpi;
        logic [15:0]  vci;
        logic         clp;
        logic [2:0]   pt;
        logic [7:0]   hec;
        logic [383:0] payload;
    } cellObs_t;

    logic clk = 1'b0;
    logic reset;
    logic clkOut;

    utopia1_atm_rx_if #(.CNT_W(CNT_W)) bus ();

    utopia1_atm_rx #(.STALL_LIMIT(STALL_LIMIT), .CNT_W(CNT_W)) dut (
        .clk_in (clk),
        .reset  (reset),
        .clk_out(clkOut),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    phyByte_t       phyQ[$];
    cellObs_t       gotQ[$];
    logic [423:0]   expQ[$];
    int nChecks = 0, nPass = 0;
    int popCount = 0, abortSeen = 0, hecErrSeen = 0, validSeen = 0;
    int readyWait = 0, cntModel = 0;
    bit clavKill = 1'b0, readyEn = 1'b1;

    task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // ATM HEC: remainder of header * x^8 divided by x^8+x^2+x+1, then coset 0x55
    function automatic logic [7:0] hecOf(input logic [31:0] hdr);
        logic [39:0] m;
        m = {hdr, 8'h00};
        for (int i = 39; i >= 8; i--)
            if (m[i]) m = m ^ (40'h107 << (i - 8));
        return m[7:0] ^ 8'h55;
    endfunction

    function automatic logic [423:0] mkCell(input logic [31:0] hdr, input bit rndPay);
        logic [423:0] c;
        for (int i = 0; i < 4; i++) c[8*i +: 8] = hdr[8*(3-i) +: 8];
        c[39:32] = hecOf(hdr);
        for (int k = 0; k < 48; k++) c[40 + 8*k +: 8] = rndPay ? 8'($urandom) : 8'(k);
        return c;
    endfunction

    function automatic cellObs_t expFields(input logic [423:0] c);
        cellObs_t e;
        logic [7:0] b [0:4];
        for (int i = 0; i < 5; i++) b[i] = c[8*i +: 8];
        e.vpi     = {b[0], b[1][7:4]};
        e.vci     = {b[1][3:0], b[2], b[3][7:4]};
        e.clp     = b[3][3];
        e.pt      = b[3][2:0];
        e.hec     = b[4];
        e.payload = c[423:40];
        return e;
    endfunction

    task automatic pushCell(input logic [423:0] c, input int n);
        for (int i = 0; i < n; i++) phyQ.push_back('{soc: (i == 0), d: c[8*i +: 8]});
    endtask

    // One clock: observe at negedge, drive PHY/core inputs, account the transfer after posedge
    task automatic step();
        logic enBefore;
        cellObs_t s;
        @(negedge clk);
        if (bus.abort)   abortSeen++;
        if (bus.hec_err) hecErrSeen++;
        if (bus.valid)   validSeen++;
        if (phyQ.size() > 0) begin
            bus.data = phyQ[0].d;
            bus.soc  = phyQ[0].soc;
        end else begin
            bus.data = 8'($urandom);
            bus.soc  = 1'b0;
        end
        bus.clav = (phyQ.size() > 0) && !clavKill;
        if (bus.valid) begin
            bus.ready = readyEn && (readyWait == 0);
            if (readyWait > 0) readyWait--;
        end else begin
            bus.ready = 1'($urandom_range(0, 1));
        end
        if (bus.valid && bus.ready) begin
            s = '{vpi: bus.vpi, vci: bus.vci, clp: bus.clp, pt: bus.pt, hec: bus.hec, payload: bus.payload};
            gotQ.push_back(s);
        end
        enBefore = bus.en;
        @(posedge clk);
        #1;
        if (!enBefore && phyQ.size() > 0) begin
            void'(phyQ.pop_front());
            popCount++;
        end
    endtask

    task automatic runPops(input int target, input string tag);
        int k = 0;
        while (popCount < target && k < 300) begin step(); k++; end
        check({tag, "_pops"}, 384'(popCount), 384'(target));
    endtask

    task automatic runDeliver(input int n, input string tag);
        int k = 0;
        while (gotQ.size() < n && k < 400) begin step(); k++; end
        check({tag, "_delivered"}, 384'(gotQ.size()), 384'(n));
        repeat (4) step();
    endtask

    task automatic checkCells(input string tag);
        cellObs_t e, g;
        check({tag, "_ncells"}, 384'(gotQ.size()), 384'(expQ.size()));
        while (expQ.size() > 0 && gotQ.size() > 0) begin
            e = expFields(expQ.pop_front());
            g = gotQ.pop_front();
            check({tag, "_vpi"}, 384'(g.vpi), 384'(e.vpi));
            check({tag, "_vci"}, 384'(g.vci), 384'(e.vci));
            check({tag, "_clp_pt"}, 384'({g.clp, g.pt}), 384'({e.clp, e.pt}));
            check({tag, "_hec"}, 384'(g.hec), 384'(e.hec));
            check({tag, "_payload"}, g.payload, e.payload);
        end
        expQ.delete();
        gotQ.delete();
        check({tag, "_count"}, 384'(bus.cell_count), 384'(CNT_W'(cntModel)));
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, "_en"}, 384'(bus.en), 384'(1));
        check({tag, "_valid"}, 384'(bus.valid), 384'(0));
        check({tag, "_abort_hecerr"}, 384'({bus.abort, bus.hec_err}), 384'(0));
        check({tag, "_count"}, 384'(bus.cell_count), 384'(0));
        check({tag, "_hdr"}, 384'({bus.vpi, bus.vci, bus.clp, bus.pt, bus.hec}), 384'(0));
        check({tag, "_payload"}, bus.payload, 384'(0));
    endtask

    initial begin
        logic [423:0] a, b, c;
        cellObs_t e;
        int base, p0;

        bus.clav = 1'b0; bus.soc = 1'b0; bus.data = 8'h00; bus.ready = 1'b0;
        reset = 1'b1;
        repeat (3) step();
        checkResetValues("reset");
        check("clk_out", 384'(clkOut), 384'(clk));
        reset = 1'b0;

        // Clean cell with known header and ramp payload
        c = mkCell(32'h12345678, 1'b0);
        pushCell(c, 53); expQ.push_back(c); cntModel++;
        validSeen = 0;
        runDeliver(1, "clean");
        check("clean_valid_cycles", 384'(validSeen), 384'(1));
        check("clean_vpi_const", 384'(gotQ[0].vpi), 384'(12'h123));
        check("clean_vci_const", 384'(gotQ[0].vci), 384'(16'h4567));
        check("clean_clp_pt_const", 384'({gotQ[0].clp, gotQ[0].pt}), 384'(4'b1000));
        checkCells("clean");

        // Back-pressure: ready held low for 10 cycles while valid
        c = mkCell(32'($urandom), 1'b1);
        pushCell(c, 53); expQ.push_back(c);
        readyEn = 1'b0;
        p0 = 0;
        while (!bus.valid && p0 < 300) begin step(); p0++; end
        e = expFields(c);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 384'(bus.valid), 384'(1));
            check("bp_en", 384'(bus.en), 384'(1));
            check("bp_fields", 384'({bus.vpi, bus.vci, bus.clp, bus.pt, bus.hec}),
                  384'({e.vpi, e.vci, e.clp, e.pt, e.hec}));
            check("bp_count_hold", 384'(bus.cell_count), 384'(CNT_W'(cntModel)));
            step();
        end
        readyEn = 1'b1;
        step();
        cntModel++;
        check("bp_valid_drop", 384'(bus.valid), 384'(0));
        checkCells("bp");

        // Flow-control stall of 5 cycles mid-cell
        c = mkCell(32'($urandom), 1'b1);
        pushCell(c, 53); expQ.push_back(c); cntModel++;
        runPops(popCount + 21, "stall");
        clavKill = 1'b1; p0 = popCount;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_en", 384'(bus.en), 384'(1));
        end
        check("stall_pops", 384'(popCount - p0), 384'(1));
        clavKill = 1'b0; abortSeen = 0;
        runDeliver(1, "stall");
        check("stall_abort", 384'(abortSeen), 384'(0));
        checkCells("stall");

        // Resync: new soc arrives at byte 30 of a cell
        a = mkCell(32'($urandom), 1'b1);
        b = mkCell(32'($urandom), 1'b1);
        pushCell(a, 30); pushCell(b, 53); expQ.push_back(b); cntModel++;
        abortSeen = 0;
        runDeliver(1, "resync");
        check("resync_abort", 384'(abortSeen), 384'(1));
        checkCells("resync");

        // Timeout: 8-cycle stall at byte 10, leftover non-soc bytes discarded, next cell delivered
        a = mkCell(32'($urandom), 1'b1);
        b = mkCell(32'($urandom), 1'b1);
        pushCell(a, 53); pushCell(b, 53); expQ.push_back(b); cntModel++;
        abortSeen = 0; base = popCount;
        runPops(base + 10, "tmo");
        clavKill = 1'b1;
        repeat (8) step();
        clavKill = 1'b0;
        runDeliver(1, "tmo");
        check("tmo_abort", 384'(abortSeen), 384'(1));
        checkCells("tmo");

        // Randomized cells with random stalls and ready latency
        for (int n = 0; n < 6; n++) begin
            c = mkCell(32'($urandom), 1'b1);
            pushCell(c, 53); expQ.push_back(c); cntModel++;
            readyWait = $urandom_range(0, 3);
            abortSeen = 0; base = popCount;
            runPops(base + $urandom_range(5, 50), "rnd");
            clavKill = 1'b1;
            repeat ($urandom_range(0, 5)) step();
            clavKill = 1'b0;
            runDeliver(1, "rnd");
            check("rnd_abort", 384'(abortSeen), 384'(0));
            checkCells("rnd");
        end

        // Reset at byte 40 discards the cell and the count
        c = mkCell(32'($urandom), 1'b1);
        pushCell(c, 53);
        runPops(popCount + 40, "rst");
        reset = 1'b1;
        step();
        checkResetValues("rst_mid");
        phyQ.delete();
        reset = 1'b0;
        cntModel = 0;
        c = mkCell(32'($urandom), 1'b1);
        pushCell(c, 53); expQ.push_back(c); cntModel++;
        runDeliver(1, "post_rst");
        checkCells("post_rst");

        // HEC: all-zero header with HEC 0x00, then with the correct 0x55
        c = mkCell(32'h0, 1'b1);
        c[39:32] = 8'h00;
        pushCell(c, 53);
        hecErrSeen = 0; validSeen = 0;
        p0 = 0;
        while (phyQ.size() > 0 && p0 < 300) begin step(); p0++; end
        repeat (6) step();
`ifdef UTOPIA_RX_HEC_CHECK_EN
        check("hec_bad_err", 384'(hecErrSeen), 384'(1));
        check("hec_bad_valid", 384'(validSeen), 384'(0));
`else
        check("hec_bad_err", 384'(hecErrSeen), 384'(0));
        expQ.push_back(c); cntModel++;
`endif
        checkCells("hec_bad");
        c = mkCell(32'h0, 1'b1);
        pushCell(c, 53); expQ.push_back(c); cntModel++;
        hecErrSeen = 0;
        runDeliver(1, "hec_good");
        check("hec_good_err", 384'(hecErrSeen), 384'(0));
        checkCells("hec_good");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule

// File: doc/utopia1_atm_rx.md
Name: utopia1_atm_rx

Overview:
UTOPIA Level 1 ATM-layer receiver, the receive-direction counterpart of the ATM transmitter. It pulls 53-byte NNI cells byte-serially from a PHY using the clav/en flow-control pair. It reassembles each cell into parallel header fields and a 48-byte payload, then hands the cell to the switch core over a valid/ready handshake. It sits between the PHY receive port and the core's cell-forwarding logic.

Parameters:
STALL_LIMIT, 255, consecutive no-transfer cycles tolerated mid-cell before the cell is aborted; 0 disables the timeout
CNT_W, 16, width of cell_count

Ports:
clk_in  input  1  receive clock; all logic runs on its rising edge
reset  input  1  synchronous, active-high reset
clk_out  output  1  equals clk_in (combinational pass-through to the PHY)
clav  input  1  PHY has a cell byte available
soc  input  1  PHY start-of-cell; marks byte 0 of a cell
data  input  8  PHY receive byte
en  output  1  active-low read enable to the PHY; a byte is transferred on every rising edge at which en==0
valid  output  1  assembled cell available to the core
ready  input  1  core accepts the cell
vpi  output  12  cell VPI
vci  output  16  cell VCI
clp  output  1  cell CLP
pt  output  3  cell payload type
hec  output  8  received HEC byte
payload  output  384  payload; byte k occupies [8k+7:8k], k=0..47
cell_count  output  CNT_W  number of cells delivered; wraps modulo 2^CNT_W
abort  output  1  one-cycle pulse when a partially received cell is discarded
hec_err  output  1  one-cycle pulse on HEC mismatch (optional feature only)

Behaviour:
- Reset (synchronous): en=1, valid=0, abort=0, hec_err=0, cell_count=0, vpi/vci/clp/pt/hec/payload=0, byte index=0, stall counter=0, state HUNT.
- en is registered. In HUNT and RECV it is updated every cycle as en <= !clav. In DELIVER it is forced to 1.
- Byte map by index i:
  - i=0: vpi[11:4]
  - i=1: {vpi[3:0], vci[15:12]}
  - i=2: vci[11:4]
  - i=3: {vci[3:0], clp, pt[2:0]}, with clp taken from data[3]
  - i=4: hec
  - i=5..52: payload byte i-5
- States:
  - HUNT: on a transfer edge with soc=1, capture byte 0, set i=1, go to RECV. A transfer with soc=0 is discarded silently.
  - RECV: on each transfer edge, capture data at index i and increment i.
    - If soc=1 on a transfer, the current cell is abandoned: pulse abort, treat the byte as byte 0 of a new cell, set i=1.
    - On capturing i=52, go to DELIVER; en becomes 1 on the next edge.
  - DELIVER: valid=1, asserted the cycle after byte 52 is captured.
    - All cell fields are held stable while valid=1.
    - On an edge with valid && ready: valid <= 0, cell_count++, go to HUNT.
    - ready while valid=0 is ignored.
- Stall timeout (STALL_LIMIT>0):
  - The counter increments on each RECV cycle with en==1 and clears on every transfer.
  - When it reaches STALL_LIMIT: pulse abort, go to HUNT, set i=0.
  - A HUNT stall never times out.
- Any byte transferred during the single cycle after entering DELIVER is a protocol error and is ignored. The PHY must not supply it, because en=1.
- Field outputs update only on capture; a partial cell overwrites the fields of the previous delivered cell.
- reset asserted mid-cell or during DELIVER: immediate return to the reset values; the pending cell is lost and not counted.
- Simultaneous abort and hec_err cannot occur; each is a single-cycle pulse.

Optional Feature:
Macro UTOPIA_RX_HEC_CHECK_EN.
- Defined: compute CRC-8 (polynomial x^8+x^2+x+1, initial value 0x00) over bytes 0..3, XOR with 0x55, and compare to byte 4 when it is captured.
  - On mismatch: pulse hec_err one cycle after byte 4 is captured, drop the cell (go to HUNT, no valid, no count), leave en driven by clav.
  - On match: normal flow.
- Undefined: no checker logic; hec_err is tied to 0; every complete cell is delivered.

Test Plan:
- Clean cell: clav=1 continuously, soc with byte 0, bytes 0x12,0x34,0x56,0x78,HEC,payload 0x00..0x2F, ready=1 -> valid rises the cycle after byte 52 for exactly 1 cycle, with vpi=0x123, vci=0x4567, clp=1, pt=0, payload byte k=k, and cell_count=1.
- Back-pressure: hold ready=0 for 10 cycles after valid -> valid and fields held stable and en=1 throughout; cell_count increments only on the ready edge.
- Flow-control stall: drop clav for 5 cycles after byte 20 -> en=1 during the stall, no bytes captured, reception resumes at byte 21, and the cell is intact.
- Resync: soc asserted at byte 30 -> abort pulses once, the new cell is captured from that byte, one good cell is delivered, and cell_count=1.
- Timeout: STALL_LIMIT=8, clav low for 8 cycles at byte 10 -> abort pulses, return to HUNT, a following non-soc byte is discarded, and the next soc cell is delivered.
- Reset and HEC: assert reset at byte 40 -> all outputs at reset values next cycle. With UTOPIA_RX_HEC_CHECK_EN and header 00 00 00 00 sent with HEC 0x00 (expected 0x55) -> hec_err pulses and no valid; with HEC 0x55 -> the cell is delivered.
